// File: rtl/camera_exposure_fsm_if.sv
// Control bus between the camera sequencer, the exposure-time register block
// and the pixel array. The sequencer takes the slave side.
interface camera_exposure_fsm_if;
    logic       Init;
    logic [4:0] EX_time;
    logic       Erase;
    logic       Expose;
    logic       NRE_1;
    logic       NRE_2;
    logic       ADC;
    logic       Adjust_en;

    modport master (
        output Init, EX_time,
        input  Erase, Expose, NRE_1, NRE_2, ADC, Adjust_en
    );

    modport slave (
        input  Init, EX_time,
        output Erase, Expose, NRE_1, NRE_2, ADC, Adjust_en
    );
endinterface

// File: rtl/camera_exposure_fsm.sv
// Capture sequencer: erase while idle, expose for a clamped number of cycles,
// then an eight-phase two-row readout with one ADC strobe per row.
// Outputs are registered decodes of the current state, so every output
// appears one cycle after the state that produces it. Reset forces the
// outputs straight to their idle values.
module camera_exposure_fsm #(
    parameter int T_MIN = 2,
    parameter int T_MAX = 30
) (
    input  logic                        Clk,
    input  logic                        Reset,
    camera_exposure_fsm_if.slave        bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXPOSE  = 2'd1,
        READOUT = 2'd2
    } state_t;

    // Output vector order: {Erase, Expose, NRE_1, NRE_2, ADC, Adjust_en}
    localparam logic [5:0] OUT_IDLE   = 6'b101101;
    localparam logic [5:0] OUT_EXPOSE = 6'b011100;
    localparam logic [5:0] OUT_ROW1   = 6'b000100;
    localparam logic [5:0] OUT_ROW1_S = 6'b000110;
    localparam logic [5:0] OUT_GAP    = 6'b001100;
    localparam logic [5:0] OUT_ROW2   = 6'b001000;
    localparam logic [5:0] OUT_ROW2_S = 6'b001010;

    state_t     r_state;
    logic [4:0] r_cnt;
    logic       r_erase;
    logic       r_expose;
    logic       r_nre_1;
    logic       r_nre_2;
    logic       r_adc;
    logic       r_adjust_en;
    logic [4:0] w_t;

    // Clamp the requested exposure into [T_MIN, T_MAX].
    function automatic logic [4:0] clamp_time(input logic [4:0] v);
        logic [4:0] res;
        if (v < 5'(T_MIN)) begin
            res = 5'(T_MIN);
        end else if (v > 5'(T_MAX)) begin
            res = 5'(T_MAX);
        end else begin
            res = v;
        end
        return res;
    endfunction

    // Output pattern for a given state and readout phase.
    function automatic logic [5:0] decode_outputs(input state_t s, input logic [2:0] p);
        logic [5:0] res;
        case (s)
            IDLE:    res = OUT_IDLE;
            EXPOSE:  res = OUT_EXPOSE;
            READOUT: begin
                case (p)
                    3'd0:    res = OUT_ROW1;
                    3'd1:    res = OUT_ROW1_S;
                    3'd2:    res = OUT_ROW1;
                    3'd3:    res = OUT_GAP;
                    3'd4:    res = OUT_ROW2;
                    3'd5:    res = OUT_ROW2_S;
                    3'd6:    res = OUT_ROW2;
                    3'd7:    res = OUT_GAP;
                    default: res = OUT_GAP;
                endcase
            end
            default: res = OUT_IDLE;
        endcase
        return res;
    endfunction

    assign w_t = clamp_time(bus.EX_time);

    // Sequencer state, exposure/phase counter and registered output lines.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= IDLE;
            r_cnt   <= 5'd0;
            {r_erase, r_expose, r_nre_1, r_nre_2, r_adc, r_adjust_en} <= OUT_IDLE;
        end else begin
            {r_erase, r_expose, r_nre_1, r_nre_2, r_adc, r_adjust_en} <=
                decode_outputs(r_state, r_cnt[2:0]);
            case (r_state)
                IDLE: begin
                    if (bus.Init) begin
                        r_cnt   <= w_t;
                        r_state <= EXPOSE;
                    end else begin
                        r_cnt   <= 5'd0;
                        r_state <= IDLE;
                    end
                end
                EXPOSE: begin
                    if (r_cnt == 5'd1) begin
                        r_cnt   <= 5'd0;
                        r_state <= READOUT;
                    end else begin
                        r_cnt   <= r_cnt - 5'd1;
                        r_state <= EXPOSE;
                    end
                end
                READOUT: begin
                    if (r_cnt == 5'd7) begin
                        r_cnt   <= 5'd0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt   <= r_cnt + 5'd1;
                        r_state <= READOUT;
                    end
                end
                default: begin
                    r_cnt   <= 5'd0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.Erase     = r_erase;
    assign bus.Expose    = r_expose;
    assign bus.NRE_1     = r_nre_1;
    assign bus.NRE_2     = r_nre_2;
    assign bus.ADC       = r_adc;
    assign bus.Adjust_en = r_adjust_en;

endmodule

// File: tb/tb_camera_exposure_fsm.sv
// Directed bench for the capture sequencer. Outputs are sampled on the
// falling clock edge; inputs change right after each sample.
module tb_camera_exposure_fsm;

    logic Clk;
    logic Reset;
    int   total;
    int   bad;
    logic [5:0] obs;

    // Output vector order: {Erase, Expose, NRE_1, NRE_2, ADC, Adjust_en}
    localparam logic [5:0] V_IDLE   = 6'b101101;
    localparam logic [5:0] V_EXPOSE = 6'b011100;

    camera_exposure_fsm_if bus ();

    camera_exposure_fsm #(.T_MIN(2), .T_MAX(30)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    assign obs = {bus.Erase, bus.Expose, bus.NRE_1, bus.NRE_2, bus.ADC, bus.Adjust_en};

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
        end
    endtask

    // Expected outputs i samples after the edge that took Init for a capture of length t.
    function automatic logic [5:0] exp_vec(input int t, input int i);
        logic [5:0] v;
        if (i <= 0 || i >= t + 9) begin
            v = V_IDLE;
        end else if (i <= t) begin
            v = V_EXPOSE;
        end else begin
            case (i - t - 1)
                0:       v = 6'b000100;
                1:       v = 6'b000110;
                2:       v = 6'b000100;
                3:       v = 6'b001100;
                4:       v = 6'b001000;
                5:       v = 6'b001010;
                6:       v = 6'b001000;
                default: v = 6'b001100;
            endcase
        end
        return v;
    endfunction

    // One capture from a single Init pulse; optional disturbance at sample glitch_at.
    task automatic capture(input string tag, input logic [4:0] ex, input int t, input int glitch_at);
        int exp_w;
        int adc_n;
        int adj_lo;
        @(negedge Clk);
        bus.Init    = 1'b1;
        bus.EX_time = ex;
        @(negedge Clk);
        bus.Init = 1'b0;
        exp_w  = 0;
        adc_n  = 0;
        adj_lo = 0;
        for (int i = 0; i < t + 14; i++) begin
            if (i > 0) @(negedge Clk);
            chk({tag, "_vec"}, int'(obs), int'(exp_vec(t, i)));
            if (bus.Expose)     exp_w++;
            if (bus.ADC)        adc_n++;
            if (!bus.Adjust_en) adj_lo++;
            if (i == glitch_at) begin
                bus.Init    = 1'b1;
                bus.EX_time = 5'd20;
            end else begin
                bus.Init = 1'b0;
            end
        end
        chk({tag, "_expose_width"}, exp_w, t);
        chk({tag, "_adc_count"}, adc_n, 2);
        chk({tag, "_adjust_low"}, adj_lo, t + 8);
    endtask

    // Start a T=10 capture, reset at sample stop_idx, then expect quiet idle.
    task automatic reset_mid(input string tag, input int stop_idx);
        int adc_n;
        @(negedge Clk);
        bus.Init    = 1'b1;
        bus.EX_time = 5'd10;
        @(negedge Clk);
        bus.Init = 1'b0;
        for (int i = 0; i <= stop_idx; i++) begin
            if (i > 0) @(negedge Clk);
            chk({tag, "_pre"}, int'(obs), int'(exp_vec(10, i)));
        end
        Reset = 1'b1;
        @(negedge Clk);
        chk({tag, "_after_reset"}, int'(obs), int'(V_IDLE));
        Reset = 1'b0;
        adc_n = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge Clk);
            if (bus.ADC) adc_n++;
            chk({tag, "_idle"}, int'(obs), int'(V_IDLE));
        end
        chk({tag, "_no_adc"}, adc_n, 0);
    endtask

    initial begin
        int erase_n;
        int overlap_n;
        total       = 0;
        bad         = 0;
        Reset       = 1'b1;
        bus.Init    = 1'b0;
        bus.EX_time = 5'd0;

        // Reset held three cycles, released with Init low.
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            chk("reset_idle", int'(obs), int'(V_IDLE));
        end

        // Nominal capture and clamp bounds.
        capture("nominal", 5'd10, 10, -1);
        capture("clamp0",  5'd0,  2,  -1);
        capture("clamp1",  5'd1,  2,  -1);
        capture("clamp31", 5'd31, 30, -1);
        capture("clamp30", 5'd30, 30, -1);

        // Init and EX_time changes during exposure are ignored.
        capture("ignored", 5'd10, 10, 3);

        // Back-to-back captures with Init held high.
        @(negedge Clk);
        bus.Init    = 1'b1;
        bus.EX_time = 5'd4;
        @(negedge Clk);
        erase_n   = 0;
        overlap_n = 0;
        for (int i = 0; i < 39; i++) begin
            if (i > 0) @(negedge Clk);
            chk("b2b_vec", int'(obs), int'(exp_vec(4, i % 13)));
            if (bus.Erase && i > 0) erase_n++;
            if (!bus.NRE_1 && !bus.NRE_2) overlap_n++;
        end
        bus.Init = 1'b0;
        chk("b2b_erase_gaps", erase_n, 2);
        chk("b2b_nre_overlap", overlap_n, 0);
        repeat (3) @(negedge Clk);
        chk("b2b_stop", int'(obs), int'(V_IDLE));

        // Reset during third exposure cycle, then during readout phase 5.
        reset_mid("rst_expose", 3);
        capture("post_rst_expose", 5'd6, 6, -1);
        reset_mid("rst_readout", 16);
        capture("post_rst_readout", 5'd10, 10, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
